exu_alu_mc: RTL and testbench

EXU_ALU_MC -- requirements
Module: exu_alu_mc

---
 rtl/exu_alu_mc.sv | 146 ++++++++++++++
 tb/tb_exu_alu_mc.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/exu_alu_mc.sv
// Integer ALU with branch compare; 1-cycle result, iterative log-step shifter when FAST_SHIFT=0.
// One op in flight: req_ready_o only in IDLE or on the response handshake; flush_i aborts and blocks accept.
module exu_alu_mc #(
  parameter int DW         = 32,
  parameter int TAG_W      = 4,
  parameter int FAST_SHIFT = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [3:0]       req_op_i,
  input  logic [DW-1:0]    req_op1_i,
  input  logic [DW-1:0]    req_op2_i,
  input  logic [TAG_W-1:0] req_tag_i,
  output logic             resp_valid_o,
  input  logic             resp_ready_i,
  output logic [DW-1:0]    resp_res_o,
  output logic             resp_cmp_o,
  output logic [TAG_W-1:0] resp_tag_o
);

  localparam int SHAMT_W = $clog2(DW);
  localparam int CNT_W   = $clog2(SHAMT_W);

  localparam logic [3:0] OP_ADD  = 4'd0,  OP_SUB  = 4'd1,  OP_SLL  = 4'd2,  OP_SLT  = 4'd3;
  localparam logic [3:0] OP_SLTU = 4'd4,  OP_XOR  = 4'd5,  OP_SRL  = 4'd6,  OP_SRA  = 4'd7;
  localparam logic [3:0] OP_OR   = 4'd8,  OP_AND  = 4'd9,  OP_BEQ  = 4'd10, OP_BNE  = 4'd11;
  localparam logic [3:0] OP_BLT  = 4'd12, OP_BLTU = 4'd13, OP_BGE  = 4'd14, OP_BGEU = 4'd15;

  typedef enum logic [1:0] {IDLE, SHIFT, RESP} state_t;

  state_t               state_q, state_d;
  logic [DW-1:0]        res_q;
  logic                 cmp_q;
  logic [TAG_W-1:0]     tag_q;
  logic [3:0]           sh_op_q;
  logic [SHAMT_W-1:0]   shamt_q;
  logic [CNT_W-1:0]     cnt_q;

  logic                 accept;
  logic                 is_shift;
  logic                 use_iter;
  logic                 slt;
  logic                 sltu;
  logic [SHAMT_W-1:0]   req_shamt;
  logic [SHAMT_W-1:0]   step;
  logic [DW-1:0]        alu_res;
  logic                 alu_cmp;
  logic [DW-1:0]        shift_stage;

  assign req_shamt = req_op2_i[SHAMT_W-1:0];
  assign slt       = $signed(req_op1_i) < $signed(req_op2_i);
  assign sltu      = req_op1_i < req_op2_i;
  assign is_shift  = (req_op_i == OP_SLL) || (req_op_i == OP_SRL) || (req_op_i == OP_SRA);
  assign use_iter  = is_shift && (FAST_SHIFT == 0);

  always_comb begin
    alu_res = '0;
    alu_cmp = 1'b0;
    case (req_op_i)
      OP_ADD:  alu_res = req_op1_i + req_op2_i;
      OP_SUB:  alu_res = req_op1_i - req_op2_i;
      OP_SLL:  alu_res = req_op1_i << req_shamt;
      OP_SLT:  alu_res = DW'(slt);
      OP_SLTU: alu_res = DW'(sltu);
      OP_XOR:  alu_res = req_op1_i ^ req_op2_i;
      OP_SRL:  alu_res = req_op1_i >> req_shamt;
      OP_SRA:  alu_res = $signed(req_op1_i) >>> req_shamt;
      OP_OR:   alu_res = req_op1_i | req_op2_i;
      OP_AND:  alu_res = req_op1_i & req_op2_i;
      OP_BEQ:  alu_cmp = (req_op1_i == req_op2_i);
      OP_BNE:  alu_cmp = (req_op1_i != req_op2_i);
      OP_BLT:  alu_cmp = slt;
      OP_BLTU: alu_cmp = sltu;
      OP_BGE:  alu_cmp = !slt;
      OP_BGEU: alu_cmp = !sltu;
      default: alu_res = '0;
    endcase
  end

  // Stage cnt shifts by 2^cnt when that amount bit is set, so every shift takes SHAMT_W stages.
  assign step = SHAMT_W'(1) << cnt_q;

  always_comb begin
    shift_stage = res_q;
    case (sh_op_q)
      OP_SLL:  shift_stage = res_q << step;
      OP_SRL:  shift_stage = res_q >> step;
      default: shift_stage = $signed(res_q) >>> step;
    endcase
  end

  always_comb begin
    req_ready_o  = !flush_i && ((state_q == IDLE) || ((state_q == RESP) && resp_ready_i));
    resp_valid_o = (state_q == RESP);
    accept       = req_valid_i && req_ready_o;
    state_d      = state_q;
    case (state_q)
      SHIFT:   if (cnt_q == CNT_W'(SHAMT_W-1)) state_d = RESP;
      RESP:    if (resp_ready_i) state_d = IDLE;
      default: state_d = state_q;
    endcase
    if (accept)  state_d = use_iter ? SHIFT : RESP;
    if (flush_i) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q   <= '0;
      cmp_q   <= 1'b0;
      tag_q   <= '0;
      sh_op_q <= '0;
      shamt_q <= '0;
      cnt_q   <= '0;
    end else if (flush_i) begin
      cnt_q   <= '0;
    end else if (accept) begin
      tag_q   <= req_tag_i;
      cnt_q   <= '0;
      sh_op_q <= req_op_i;
      shamt_q <= req_shamt;
      if (use_iter) begin
        res_q <= req_op1_i;
        cmp_q <= 1'b0;
      end else begin
        res_q <= alu_res;
        cmp_q <= alu_cmp;
      end
    end else if (state_q == SHIFT) begin
      if (shamt_q[cnt_q]) res_q <= shift_stage;
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign resp_res_o = res_q;
  assign resp_cmp_o = cmp_q;
  assign resp_tag_o = tag_q;

endmodule

// File: tb/tb_exu_alu_mc.sv
// Bench for exu_alu_mc: directed literal cases plus randomized traffic against a queue-based model.
module tb_exu_alu_mc;

  localparam int DW = 32;
  localparam int TAG_W = 4;
  localparam int SHAMT_W = 5;
  // A shift spends SHAMT_W cycles in SHIFT, then RESP; other ops go straight to RESP.
  localparam int SHIFT_LAT = SHAMT_W + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush, req_valid, req_ready, resp_valid, resp_ready, resp_cmp;
  logic [3:0] req_op;
  logic [DW-1:0] req_op1, req_op2, resp_res;
  logic [TAG_W-1:0] req_tag, resp_tag;

  logic f_valid, f_ready, f_resp_valid, f_resp_cmp;
  logic [3:0] f_op;
  logic [DW-1:0] f_op1, f_op2, f_res;
  logic [TAG_W-1:0] f_tag, f_resp_tag;

  int n_checks = 0;
  int n_err = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  exu_alu_mc #(.DW(DW), .TAG_W(TAG_W), .FAST_SHIFT(0)) dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_op_i(req_op), .req_op1_i(req_op1), .req_op2_i(req_op2), .req_tag_i(req_tag),
    .resp_valid_o(resp_valid), .resp_ready_i(resp_ready), .resp_res_o(resp_res),
    .resp_cmp_o(resp_cmp), .resp_tag_o(resp_tag));

  exu_alu_mc #(.DW(DW), .TAG_W(TAG_W), .FAST_SHIFT(1)) dut_f (
    .clk(clk), .rst_n(rst_n), .flush_i(1'b0), .req_valid_i(f_valid), .req_ready_o(f_ready),
    .req_op_i(f_op), .req_op1_i(f_op1), .req_op2_i(f_op2), .req_tag_i(f_tag),
    .resp_valid_o(f_resp_valid), .resp_ready_i(1'b1), .resp_res_o(f_res),
    .resp_cmp_o(f_resp_cmp), .resp_tag_o(f_resp_tag));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: {cmp, res} from the instruction-set definition.
  function automatic logic [DW:0] model(input logic [3:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    int amt;
    logic [DW-1:0] r;
    logic c;
    amt = int'(b[4:0]);
    r = '0;
    c = 1'b0;
    case (op)
      4'd0: r = a + b;
      4'd1: r = a - b;
      4'd2: r = a << amt;
      4'd3: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd4: r = (a < b) ? 32'd1 : 32'd0;
      4'd5: r = a ^ b;
      4'd6: r = a >> amt;
      4'd7: r = $signed(a) >>> amt;
      4'd8: r = a | b;
      4'd9: r = a & b;
      4'd10: c = (a == b);
      4'd11: c = (a != b);
      4'd12: c = ($signed(a) < $signed(b));
      4'd13: c = (a < b);
      4'd14: c = ($signed(a) >= $signed(b));
      default: c = (a >= b);
    endcase
    return {c, r};
  endfunction

  function automatic int latency(input logic [3:0] op);
    return (op == 4'd2 || op == 4'd6 || op == 4'd7) ? SHIFT_LAT : 1;
  endfunction

  typedef struct {
    logic [DW-1:0]    res;
    logic             cmp;
    logic [TAG_W-1:0] tag;
    int               due;
  } exp_t;

  exp_t q[$];
  exp_t e;
  logic busy, in_resp, rdy_exp;
  logic [DW:0] m;

  // Compare process: inputs are stable at negedge, so this sees exactly what the next edge will act on.
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      chk("reset_valid", resp_valid, 1'b0);
    end else begin
      busy = (q.size() > 0);
      in_resp = busy && (cyc >= q[0].due);
      rdy_exp = !flush && (!busy || (in_resp && resp_ready));
      chk("req_ready", req_ready, rdy_exp);
      chk("resp_valid", resp_valid, in_resp);
      if (resp_valid && in_resp) begin
        chk("resp_res", resp_res, q[0].res);
        chk("resp_cmp", resp_cmp, q[0].cmp);
        chk("resp_tag", resp_tag, q[0].tag);
      end
      if (flush) begin
        q.delete();
      end else begin
        if (in_resp && resp_ready) void'(q.pop_front());
        if (req_valid && rdy_exp) begin
          m = model(req_op, req_op1, req_op2);
          e.res = m[DW-1:0];
          e.cmp = m[DW];
          e.tag = req_tag;
          e.due = cyc + latency(req_op);
          q.push_back(e);
        end
      end
    end
  end

  task automatic step(input logic v, input logic [3:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                      input logic [TAG_W-1:0] tag, input logic rr, input logic fl);
    @(posedge clk);
    #1;
    req_valid = v; req_op = op; req_op1 = a; req_op2 = b; req_tag = tag;
    resp_ready = rr; flush = fl;
    @(negedge clk);
  endtask

  task automatic f_step(input logic v, input logic [3:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic [TAG_W-1:0] tag);
    @(posedge clk);
    #1;
    f_valid = v; f_op = op; f_op1 = a; f_op2 = b; f_tag = tag;
    @(negedge clk);
  endtask

  function automatic logic [DW-1:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      4: return 32'($urandom_range(0, 40));
      default: return 32'($urandom());
    endcase
  endfunction

  logic [DW-1:0] ra, rb;
  logic [3:0] rop;

  initial begin
    flush = 0; req_valid = 0; req_op = 0; req_op1 = 0; req_op2 = 0; req_tag = 0; resp_ready = 1;
    f_valid = 0; f_op = 0; f_op1 = 0; f_op2 = 0; f_tag = 0;
    #12;
    chk("rst_valid", resp_valid, 1'b0);
    chk("rst_res", resp_res, 32'h0);
    chk("rst_cmp", resp_cmp, 1'b0);
    chk("rst_tag", resp_tag, 4'h0);
    @(posedge clk);
    #1 rst_n = 1;
    // First request in the first cycle after reset release.
    req_valid = 1; req_op = 4'd0; req_op1 = 32'hFFFF_FFFF; req_op2 = 32'd2; req_tag = 4'd3;
    @(negedge clk);
    chk("add_ready", req_ready, 1'b1);
    step(0, 0, 0, 0, 0, 1, 0);
    chk("add_valid", resp_valid, 1'b1);
    chk("add_res", resp_res, 32'h0000_0001);
    chk("add_cmp", resp_cmp, 1'b0);
    chk("add_tag", resp_tag, 4'd3);
    step(0, 0, 0, 0, 0, 1, 0);

    step(1, 4'd7, 32'h8000_0000, 32'h24, 4'd5, 1, 0);
    for (int i = 0; i < SHAMT_W; i++) begin
      step(0, 0, 0, 0, 0, 1, 0);
      chk("sra_shift_ready", req_ready, 1'b0);
      chk("sra_shift_valid", resp_valid, 1'b0);
    end
    step(0, 0, 0, 0, 0, 1, 0);
    chk("sra_valid", resp_valid, 1'b1);
    chk("sra_res", resp_res, 32'hF800_0000);
    chk("sra_tag", resp_tag, 4'd5);

    f_step(1, 4'd7, 32'h8000_0000, 32'h24, 4'd5);
    chk("fsra_ready", f_ready, 1'b1);
    f_step(0, 0, 0, 0, 0);
    chk("fsra_valid", f_resp_valid, 1'b1);
    chk("fsra_res", f_res, 32'hF800_0000);
    for (int i = 0; i < 12; i++) begin
      rop = (i % 3 == 0) ? 4'd2 : ((i % 3 == 1) ? 4'd6 : 4'd7);
      ra = pick();
      rb = 32'($urandom());
      f_step(1, rop, ra, rb, 4'(i));
      f_step(0, 0, 0, 0, 0);
      m = model(rop, ra, rb);
      chk("fshift_valid", f_resp_valid, 1'b1);
      chk("fshift_res", f_res, m[DW-1:0]);
    end

    step(1, 4'd12, 32'hFFFF_FFFE, 32'd1, 4'd1, 1, 0);
    step(1, 4'd13, 32'hFFFF_FFFE, 32'd1, 4'd2, 1, 0);
    chk("blt_cmp", resp_cmp, 1'b1);
    chk("blt_res", resp_res, 32'h0);
    chk("blt_b2b_ready", req_ready, 1'b1);
    step(0, 0, 0, 0, 0, 1, 0);
    chk("bltu_valid", resp_valid, 1'b1);
    chk("bltu_cmp", resp_cmp, 1'b0);
    chk("bltu_tag", resp_tag, 4'd2);

    step(1, 4'd5, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 4'd4, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(1, 4'd9, 32'h1234_5678, 32'h0000_FFFF, 4'd6, 0, 0);
      chk("stall_valid", resp_valid, 1'b1);
      chk("stall_res", resp_res, 32'hFF00_FF00);
      chk("stall_ready", req_ready, 1'b0);
    end
    step(1, 4'd9, 32'h1234_5678, 32'h0000_FFFF, 4'd6, 1, 0);
    chk("hs_ready", req_ready, 1'b1);
    step(0, 0, 0, 0, 0, 1, 0);
    chk("and_valid", resp_valid, 1'b1);
    chk("and_res", resp_res, 32'h0000_5678);
    chk("and_tag", resp_tag, 4'd6);

    step(1, 4'd2, 32'd1, 32'd3, 4'd7, 1, 0);
    step(0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 1, 0);
    step(1, 4'd0, 32'd5, 32'd5, 4'd8, 1, 1);
    chk("flush_ready", req_ready, 1'b0);
    step(0, 0, 0, 0, 0, 1, 0);
    chk("flush_idle_ready", req_ready, 1'b1);
    for (int i = 0; i < 6; i++) begin
      step(0, 0, 0, 0, 0, 1, 0);
      chk("flush_no_resp", resp_valid, 1'b0);
    end

    step(1, 4'd8, 32'h0000_00A0, 32'h0000_000B, 4'd9, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("or_valid", resp_valid, 1'b1);
    chk("or_res", resp_res, 32'h0000_00AB);
    #2 rst_n = 0;
    #1;
    chk("arst_valid", resp_valid, 1'b0);
    chk("arst_res", resp_res, 32'h0);
    chk("arst_tag", resp_tag, 4'h0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1;
    resp_ready = 1;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 0, 0, 0, 1, 0);
      chk("arst_no_resp", resp_valid, 1'b0);
    end

    for (int i = 0; i < 3000; i++) begin
      rop = 4'($urandom_range(0, 15));
      ra = pick();
      rb = ($urandom_range(0, 7) == 0) ? ra : pick();
      step($urandom_range(0, 2) != 0, rop, ra, rb, 4'($urandom()),
           $urandom_range(0, 3) != 0, $urandom_range(0, 49) == 0);
    end
    for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 0, 1, 0);
    chk("drain_empty", 64'(q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
